// File: rtl/reg_apb_bridge.sv
// Register-bus to multi-slave APB bridge.
// Decodes the slave index from the request address, runs one APB SETUP/ACCESS
// transfer, and returns a single-cycle ack. Decode, slave and timeout failures
// are all reported on error.
module reg_apb_bridge #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_SLAVES      = 4,
  parameter int unsigned SLAVE_SPAN_BITS = 12,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  // register-bus side
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic                             valid,
  input  logic                             read,
  input  logic                             write,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             ack,
  output logic                             error,
  // APB side
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic                             pwrite,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int unsigned SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned IDX_W   = SEL_W + 1;
  localparam int unsigned HI_LSB  = SLAVE_SPAN_BITS + SEL_W;
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel_idx;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0]      addr_idx;
  logic                  hi_bits_set;
  logic                  dec_err;
  logic                  req_one;
  logic                  req_both;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic [DATA_WIDTH-1:0] prdata_sel;
  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  timeout_hit;

  // Address decode of the incoming request
  assign addr_idx    = addr[SLAVE_SPAN_BITS +: SEL_W];
  assign hi_bits_set = |(addr >> HI_LSB);
  assign dec_err     = ({1'b0, addr_idx} >= IDX_W'(NUM_SLAVES)) || hi_bits_set;
  assign req_one     = valid && (read ^ write);
  assign req_both    = valid && read && write;

  // Access-phase timeout detection; a zero limit disables it
  assign cnt_inc     = cnt + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // One-hot select for the request and return-path mux for the latched slave
  always_comb begin
    dec_onehot  = '0;
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (addr_idx == SEL_W'(i)) begin
        dec_onehot[i] = 1'b1;
      end
      if (sel_idx == SEL_W'(i)) begin
        prdata_sel  = prdata[i*DATA_WIDTH +: DATA_WIDTH];
        pready_sel  = pready[i];
        pslverr_sel = pslverr[i];
      end
    end
  end

  // Transfer FSM with registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      sel_idx <= '0;
      cnt     <= '0;
      rdata   <= '0;
      ack     <= 1'b0;
      error   <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pwrite  <= 1'b0;
      psel    <= '0;
      penable <= 1'b0;
    end else begin
      ack   <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_one) begin
            paddr   <= addr;
            pwdata  <= wdata;
            pwrite  <= write;
            sel_idx <= addr_idx;
            if (dec_err) begin
              state <= ST_RESP;
              ack   <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= ST_SETUP;
              psel  <= dec_onehot;
              cnt   <= '0;
            end
          end else if (req_both) begin
            state <= ST_RESP;
            ack   <= 1'b1;
            error <= 1'b1;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (pready_sel) begin
            state   <= ST_RESP;
            ack     <= 1'b1;
            error   <= pslverr_sel;
            psel    <= '0;
            penable <= 1'b0;
            if (!pwrite) begin
              rdata <= prdata_sel;
            end
          end else if (timeout_hit) begin
            state   <= ST_RESP;
            ack     <= 1'b1;
            error   <= 1'b1;
            psel    <= '0;
            penable <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_apb_bridge.sv
// Self-checking bench for reg_apb_bridge: directed cases followed by random
// transfers, checked cycle by cycle against a transaction-level response model.
module tb_reg_apb_bridge;

  localparam int NSLV = 4;
  localparam int TMO  = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr, wdata, rdata, paddr, pwdata;
  logic         valid, read, write, ack, error, pwrite, penable;
  logic [3:0]   psel, pready, pslverr;
  logic [127:0] prdata;

  // model state
  logic [31:0] exp_rdata, exp_paddr, exp_pwdata;
  logic        exp_pwrite;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_apb_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .NUM_SLAVES     (NSLV),
    .SLAVE_SPAN_BITS(12),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .valid  (valid),
    .read   (read),
    .write  (write),
    .rdata  (rdata),
    .ack    (ack),
    .error  (error),
    .paddr  (paddr),
    .pwdata (pwdata),
    .pwrite (pwrite),
    .psel   (psel),
    .penable(penable),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Random noise on every slave; the addressed slave follows the scripted response
  task automatic drive_slave(input int sel, input bit active, input logic rdy,
                             input logic serr, input logic [31:0] rv);
    pready  = 4'($urandom);
    pslverr = 4'($urandom);
    for (int i = 0; i < NSLV; i++) prdata[i*32 +: 32] = $urandom;
    if (active) begin
      pready[sel]          = rdy;
      pslverr[sel]         = serr;
      prdata[sel*32 +: 32] = rv;
    end
  endtask

  // Cycles with no accepted request: nothing may move
  task automatic idle(input int n, input logic v);
    valid = v; read = 1'b0; write = 1'b0; addr = $urandom; wdata = $urandom;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive_slave(0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("idle_ack", 32'(ack), 32'd0);
      chk("idle_err", 32'(error), 32'd0);
      chk("idle_psel", 32'(psel), 32'd0);
      chk("idle_penable", 32'(penable), 32'd0);
      chk("idle_rdata", rdata, exp_rdata);
      chk("idle_paddr", paddr, exp_paddr);
    end
    valid = 1'b0;
  endtask

  // One request presented in an idle cycle. waits = ACCESS cycles with the
  // addressed slave not ready before it answers.
  task automatic xfer(input logic [31:0] a, input logic rd, input logic wr,
                      input logic [31:0] wd, input int waits, input logic serr,
                      input logic [31:0] rv);
    int          slave;
    bit          derr;
    int          ackc;
    logic        experr;
    logic [3:0]  oh;
    logic [31:0] rd_new;
    slave = int'(a / 32'd4096);
    derr  = (slave >= NSLV) || (rd && wr);
    if (derr) begin
      ackc = 1; experr = 1'b1;
    end else if (waits < TMO) begin
      ackc = 3 + waits; experr = serr;
    end else begin
      ackc = 2 + TMO; experr = 1'b1;
    end
    oh     = derr ? 4'd0 : 4'(32'd1 << slave);
    rd_new = exp_rdata;
    if (!derr && rd && waits < TMO) rd_new = rv;
    if (rd ^ wr) begin
      exp_paddr = a; exp_pwdata = wd; exp_pwrite = wr;
    end
    addr = a; wdata = wd; read = rd; write = wr; valid = 1'b1;
    drive_slave(slave, !derr, 1'b0, serr, rv);
    for (int k = 1; k <= ackc; k++) begin
      @(negedge clk);
      drive_slave(slave, !derr, (k >= 2 + waits), serr, rv);
      chk("ack", 32'(ack), 32'(k == ackc));
      chk("error", 32'(error), (k == ackc) ? 32'(experr) : 32'd0);
      chk("rdata", rdata, (k == ackc) ? rd_new : exp_rdata);
      chk("psel", 32'(psel), (k < ackc) ? 32'(oh) : 32'd0);
      chk("penable", 32'(penable), 32'(!derr && k >= 2 && k < ackc));
      chk("paddr", paddr, exp_paddr);
      chk("pwdata", pwdata, exp_pwdata);
      chk("pwrite", 32'(pwrite), 32'(exp_pwrite));
    end
    exp_rdata = rd_new;
    valid = 1'b0; read = 1'b0; write = 1'b0;
    @(negedge clk);
    drive_slave(0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("post_ack", 32'(ack), 32'd0);
    chk("post_psel", 32'(psel), 32'd0);
    chk("post_rdata", rdata, exp_rdata);
  endtask

  initial begin
    exp_rdata = '0; exp_paddr = '0; exp_pwdata = '0; exp_pwrite = 1'b0;
    reset = 1'b1; valid = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wdata = '0;
    drive_slave(0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    reset = 1'b0;

    // zero-wait write, accepted in the first cycle out of reset
    xfer(32'h0000_1010, 1'b0, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    // read with two wait states, then rdata holds
    xfer(32'h0000_3004, 1'b1, 1'b0, 32'h0, 2, 1'b0, 32'h12345678);
    idle(3, 1'b0);
    // valid with neither read nor write is ignored
    idle(3, 1'b1);
    // decode errors
    xfer(32'h0001_0000, 1'b1, 1'b0, 32'h0, 0, 1'b0, 32'hAAAA5555);
    xfer(32'h0001_0000, 1'b1, 1'b1, 32'h0, 0, 1'b0, 32'hAAAA5555);
    xfer(32'h0000_2000, 1'b1, 1'b1, 32'h1, 0, 1'b0, 32'hAAAA5555);
    // slave error, then back-to-back read of slave 2
    xfer(32'h0000_0040, 1'b0, 1'b1, 32'h0BAD_F00D, 0, 1'b1, 32'h0);
    xfer(32'h0000_2008, 1'b1, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_0002);
    // pslverr read still loads rdata
    xfer(32'h0000_2010, 1'b1, 1'b0, 32'h0, 1, 1'b1, 32'h5A5A_0003);
    // timeout, then ready on the last access cycle
    xfer(32'h0000_1000, 1'b1, 1'b0, 32'h0, 100, 1'b0, 32'h1111_2222);
    xfer(32'h0000_1000, 1'b1, 1'b0, 32'h0, TMO - 1, 1'b0, 32'h3333_4444);

    // reset during ACCESS aborts without ack
    addr = 32'h0000_2000; wdata = 32'h0; read = 1'b1; write = 1'b0; valid = 1'b1;
    drive_slave(2, 1'b1, 1'b0, 1'b0, 32'h7777_7777);
    repeat (3) @(negedge clk);
    chk("pre_rst_penable", 32'(penable), 32'd1);
    chk("pre_rst_psel", 32'(psel), 32'b0100);
    reset = 1'b1;
    #1;
    exp_rdata = '0; exp_paddr = '0; exp_pwdata = '0; exp_pwrite = 1'b0;
    chk("arst_psel", 32'(psel), 32'd0);
    chk("arst_penable", 32'(penable), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_paddr", paddr, 32'd0);
    valid = 1'b0; read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(4, 1'b0);
    xfer(32'h0000_1020, 1'b1, 1'b0, 32'h0, 0, 1'b0, 32'h0101_0101);

    // random transfers
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      logic        rd, wr;
      int          r;
      r = int'($urandom_range(0, 9));
      if (r < 8) a = {18'd0, 2'($urandom_range(0, 3)), 12'($urandom)};
      else       a = $urandom;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        rd = 1'b1; wr = 1'b1;
      end else begin
        rd = r[0]; wr = !r[0];
      end
      xfer(a, rd, wr, $urandom, int'($urandom_range(0, 10)), 1'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_apb_bridge.md
# reg_apb_bridge

Bridges one register-bus master (ADDR/WDATA/VALID/READ/WRITE, ACK/RDATA/ERROR) onto an APB segment with `NUM_SLAVES` decoded slaves. It generalises the single-slave APB attachment with four additions:
- per-slave PSEL decode,
- a multiplexed read-data return,
- an access timeout,
- error reporting for decode, slave and timeout failures.

It sits between the CPU-side register master and the peripheral APB slaves, in a single clock domain.

## Interface
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- NUM_SLAVES, 4, number of APB slaves; range 1..16.
- SLAVE_SPAN_BITS, 12, log2 of each slave's address window.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles; 0 disables the timeout.

Clock, reset and register-bus side:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- ADDR  in  ADDR_WIDTH  request address.
- WDATA  in  DATA_WIDTH  write data.
- VALID  in  1  request valid.
- READ  in  1  read request.
- WRITE  in  1  write request.
- RDATA  out  DATA_WIDTH  read data.
- ACK  out  1  completion, single-cycle pulse.
- ERROR  out  1  error flag, qualified by ACK.

APB side:
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB enable.
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.

## Operation
**Decode**
- SEL_W = max(1, clog2(NUM_SLAVES)).
- idx = ADDR[SLAVE_SPAN_BITS +: SEL_W].
- Decode error if idx >= NUM_SLAVES, or if any ADDR bit above SLAVE_SPAN_BITS+SEL_W is set.

**FSM states:** IDLE, SETUP, ACCESS, RESP.

**IDLE**
- Accept when VALID=1 and exactly one of READ/WRITE is 1.
- On accept, capture PADDR=ADDR, PWDATA=WDATA, PWRITE=WRITE and idx.
- If decoded OK, go to SETUP. On a decode error, go to RESP with ERROR=1.
- VALID with READ=WRITE=1 goes to RESP with ERROR=1. No PSEL is driven in either error case.
- VALID with READ=WRITE=0 is ignored; stay in IDLE.

**SETUP**
- PSEL[idx]=1, PENABLE=0.
- Always go to ACCESS next.

**ACCESS**
- PSEL[idx]=1, PENABLE=1. Timeout counter increments each cycle.
- If PREADY[idx]=1:
  - go to RESP with ERROR=PSLVERR[idx];
  - on reads, RDATA is loaded from the idx slice of PRDATA.
- Else if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES:
  - go to RESP with ERROR=1;
  - RDATA is not updated.
- PREADY in the same cycle as a timeout wins: the transfer completes normally.

**RESP**
- ACK=1 for exactly one cycle; PSEL=0, PENABLE=0.
- Then return to IDLE.

**Registers and output hold rules**
- All outputs are registered.
- RDATA changes only on a successful or PSLVERR read completion, and holds otherwise.
- PADDR, PWDATA and PWRITE change only on accept, and hold between transfers.
- The timeout counter clears on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1).
- ERROR is 0 whenever ACK=0.

## Timing
**Reset**
- RESET asserts all outputs immediately: RDATA=0, ACK=0, ERROR=0, PADDR=0, PWDATA=0, PWRITE=0, PSEL=0, PENABLE=0.
- FSM goes to IDLE and the counter to 0.
- A transfer in flight is dropped with no ACK.
- First accept can occur in the first cycle after RESET deasserts.

**Latency** (request sampled in cycle 0, IDLE)
- Zero-wait slave: SETUP in cycle 1, ACCESS in cycle 2, ACK in cycle 3.
- Each PREADY=0 ACCESS cycle adds one cycle.
- Error paths (decode error, READ=WRITE=1): ACK in cycle 1.
- Timeout: ACK in cycle 2+TIMEOUT_CYCLES.

**Handshake with the master**
- The master holds VALID/ADDR/WDATA/READ/WRITE stable until it samples ACK.
- The bridge samples requests only in IDLE, so held VALID in other states is harmless.
- Back-to-back: a new request presented in the cycle after ACK is accepted in that cycle.

**Protocol invariants**
- At most one PSEL bit is set.
- PENABLE=1 only while PSEL≠0.

## Test plan
Defaults unless stated: NUM_SLAVES=4, SLAVE_SPAN_BITS=12.

1. **Zero-wait write.** Write ADDR=0x0000_1010, WDATA=0xDEADBEEF, PREADY[1]=1.
   - Cycle 1: PSEL=0010, PENABLE=0, PADDR=0x1010, PWRITE=1.
   - Cycle 2: PENABLE=1.
   - Cycle 3: ACK=1, ERROR=0.
2. **Read with wait states.** Read ADDR=0x0000_3004, PREADY[3] low for 2 ACCESS cycles, PRDATA slice 3=0x12345678.
   - ACK in cycle 5, RDATA=0x12345678, ERROR=0.
   - RDATA holds after the transfer.
3. **Decode error.**
   - Read ADDR=0x0001_0000 (bit 16 set): PSEL stays 0; ACK=1, ERROR=1 in cycle 1; RDATA unchanged.
   - Repeat with READ=WRITE=1: same response.
4. **Slave error.** Write to slave 0 with PREADY[0]=1, PSLVERR[0]=1.
   - ACK=1 with ERROR=1 in cycle 3.
   - An immediately following back-to-back read of slave 2 completes with ERROR=0.
5. **Timeout.** TIMEOUT_CYCLES=8, PREADY stuck at 0.
   - PSEL/PENABLE stay high for 8 ACCESS cycles, then drop.
   - ACK=1, ERROR=1 in cycle 10.
   - Repeat with PREADY=1 in the 8th ACCESS cycle: ERROR=0.
6. **Reset mid-transfer.** Assert RESET during ACCESS.
   - PSEL=0, PENABLE=0, ACK=0 without waiting for a clock edge; no ACK ever for the aborted transfer.
   - After release, a read of slave 1 completes in 3 cycles.
